// File: rtl/zx_ula_io.sv
// ULA control stage: frame counter, maskable INT generation and port 0xFE read/write decode.
// Optional feature macro INTACK_CLEAR_EN: an interrupt acknowledge ends the INT pulse early.
module zx_ula_io #(
    parameter int unsigned FRAME_TSTATES = 69888,
    parameter int unsigned INT_LEN       = 32,
    parameter int unsigned CNT_W         = 17
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      address_bus,
    input  logic [7:0]       data_in,
    input  logic             iorq_n,
    input  logic             rd_n,
    input  logic             wr_n,
    input  logic             m1_n,
    input  logic             ear,
    input  logic [4:0]       kb_col_n,
    output logic             int_n,
    output logic [7:0]       data_out,
    output logic             data_oe,
    output logic [2:0]       border,
    output logic             mic,
    output logic             beeper,
    output logic             frame_tick,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FRAME_TSTATES - 1);
    localparam logic [CNT_W-1:0] CNT_INT_END = CNT_W'(INT_LEN);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrapped_q, wrapped_d;
    logic             int_n_q, int_n_d;
    logic             tick_q, tick_d;
    logic             wr_prev_q;
    logic [2:0]       border_q;
    logic             mic_q;
    logic             beeper_q;
    logic             wrap;
    logic             in_window;
    logic             io_rd;
    logic             io_wr;
    logic             wr_strobe;
    logic             unused_bits;

    // Row select lives in the keyboard matrix; only A0 takes part in the port decode here.
    assign unused_bits = ^{address_bus[15:1], data_in[7:5]};

    // ------------------------------------------------------------------
    // Frame counter and interrupt window
    // ------------------------------------------------------------------
    always_comb begin
        wrap      = (cnt_q == CNT_LAST);
        cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
        wrapped_d = wrapped_q | wrap;
        tick_d    = wrap;
        // The window only exists once a frame boundary has been crossed, so the counter
        // sitting at zero straight out of reset does not raise INT.
        in_window = wrapped_d && (cnt_d < CNT_INT_END);
    end

`ifdef INTACK_CLEAR_EN
    logic ack_q, ack_d;
    logic ack_seen;

    always_comb begin
        ack_seen = !m1_n && !iorq_n && !int_n_q;
        ack_d    = wrap ? 1'b0 : (ack_q | ack_seen);
        int_n_d  = !(in_window && !ack_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
        end
    end
`else
    always_comb begin
        int_n_d = !in_window;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            wrapped_q <= 1'b0;
            int_n_q   <= 1'b1;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            wrapped_q <= wrapped_d;
            int_n_q   <= int_n_d;
            tick_q    <= tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Port 0xFE decode; interrupt acknowledge (M1 low) is never a port access
    // ------------------------------------------------------------------
    always_comb begin
        io_rd     = !iorq_n && !rd_n && m1_n && !address_bus[0];
        io_wr     = !iorq_n && !wr_n && m1_n && !address_bus[0];
        wr_strobe = io_wr && !wr_prev_q;
    end

    // A held write latches once, with the data present on its first cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_prev_q <= 1'b0;
            border_q  <= 3'b000;
            mic_q     <= 1'b0;
            beeper_q  <= 1'b0;
        end else begin
            wr_prev_q <= io_wr;
            if (wr_strobe) begin
                border_q <= data_in[2:0];
                mic_q    <= data_in[3];
                beeper_q <= data_in[4];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign int_n      = int_n_q;
    assign frame_tick = tick_q;
    assign frame_cnt  = cnt_q;
    assign border     = border_q;
    assign mic        = mic_q;
    assign beeper     = beeper_q;
    assign data_oe    = io_rd;
    assign data_out   = {1'b1, ear, 1'b1, kb_col_n};

`ifndef SYNTHESIS
    cnt_in_range: assert property (@(posedge clk) disable iff (!reset_n)
        frame_cnt <= CNT_LAST);
    tick_at_zero: assert property (@(posedge clk) disable iff (!reset_n)
        frame_tick |-> (frame_cnt == '0));
    int_after_wrap: assert property (@(posedge clk) disable iff (!reset_n)
        !int_n |-> wrapped_q);
`endif

endmodule

// File: tb/tb_zx_ula_io.sv
// Randomised self-checking bench for zx_ula_io against a frame-arithmetic reference model.
module tb_zx_ula_io;

    localparam int F  = 100;
    localparam int IL = 4;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [15:0]   address_bus;
    logic [7:0]    data_in;
    logic          iorq_n, rd_n, wr_n, m1_n, ear;
    logic [4:0]    kb_col_n;
    logic          int_n, data_oe, mic, beeper, frame_tick;
    logic [7:0]    data_out;
    logic [2:0]    border;
    logic [CW-1:0] frame_cnt;

    zx_ula_io #(
        .FRAME_TSTATES(F),
        .INT_LEN      (IL),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address_bus(address_bus),
        .data_in    (data_in),
        .iorq_n     (iorq_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .m1_n       (m1_n),
        .ear        (ear),
        .kb_col_n   (kb_col_n),
        .int_n      (int_n),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .border     (border),
        .mic        (mic),
        .beeper     (beeper),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: everything derives from the number of edges since reset release.
    int         edges;
    logic       acked;
    logic       wr_prev;
    logic [2:0] m_border;
    logic       m_mic, m_beeper;
    logic       m_io_wr, m_io_rd;
    logic [31:0] exp_fc;
    logic       exp_tick, exp_int_n;

    always_comb begin
        m_io_wr   = !iorq_n && !wr_n && m1_n && !address_bus[0];
        m_io_rd   = !iorq_n && !rd_n && m1_n && !address_bus[0];
        exp_fc    = edges % F;
        exp_tick  = (edges >= F) && (edges % F == 0);
        exp_int_n = !((edges >= F) && (edges % F < IL) && !acked);
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edges    <= 0;
            acked    <= 1'b0;
            wr_prev  <= 1'b0;
            m_border <= 3'b000;
            m_mic    <= 1'b0;
            m_beeper <= 1'b0;
        end else begin
            edges   <= edges + 1;
            wr_prev <= m_io_wr;
            if (m_io_wr && !wr_prev) begin
                m_border <= data_in[2:0];
                m_mic    <= data_in[3];
                m_beeper <= data_in[4];
            end
`ifdef INTACK_CLEAR_EN
            if ((edges + 1) % F == 0) acked <= 1'b0;
            else if (!m1_n && !iorq_n && !exp_int_n) acked <= 1'b1;
`endif
        end
    end

    always @(negedge clk) begin
        check("frame_cnt", 32'(frame_cnt), exp_fc);
        check("int_n", 32'(int_n), 32'(exp_int_n));
        check("frame_tick", 32'(frame_tick), 32'(exp_tick));
        check("border", 32'(border), 32'(m_border));
        check("mic", 32'(mic), 32'(m_mic));
        check("beeper", 32'(beeper), 32'(m_beeper));
        check("data_oe", 32'(data_oe), 32'(m_io_rd));
        check("data_out", 32'(data_out), {24'h0, 1'b1, ear, 1'b1, kb_col_n});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        iorq_n      = 1'b1;
        rd_n        = 1'b1;
        wr_n        = 1'b1;
        m1_n        = 1'b1;
        address_bus = 16'hFFFF;
        data_in     = 8'h00;
    endtask

    task automatic wait_wrap();
        int i;
        i = 0;
        while (!(edges >= F && edges % F == 0) && i < 3 * F) begin
            step();
            i++;
        end
        check("wrap_found", 32'(edges >= F && edges % F == 0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        ear      = 1'b0;
        kb_col_n = 5'h1F;
        idle();
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Frame timing after release
        repeat (99) step();
        check("pre_int_int_n", 32'(int_n), 32'd1);
        check("pre_int_cnt", 32'(frame_cnt), 32'd99);
        step();
        check("first_int_n", 32'(int_n), 32'd0);
        check("first_tick", 32'(frame_tick), 32'd1);
        check("first_cnt", 32'(frame_cnt), 32'd0);
        step();
        check("tick_one_cycle", 32'(frame_tick), 32'd0);
        step(); step();
        check("int_low_edge103", 32'(int_n), 32'd0);
        step();
        check("int_high_edge104", 32'(int_n), 32'd1);

        // Read port, same-cycle response
        address_bus = 16'hFDFE; iorq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b1;
        kb_col_n = 5'b11110; ear = 1'b1;
        #1;
        check("read_oe", 32'(data_oe), 32'd1);
        check("read_data", 32'(data_out), 32'hFE);
        address_bus = 16'hFDFF;
        #1;
        check("read_odd_oe", 32'(data_oe), 32'd0);
        idle();
        step();

        // Held write latches once with first-cycle data
        address_bus = 16'h00FE; data_in = 8'h15; iorq_n = 1'b0; wr_n = 1'b0;
        step();
        check("wr_border", 32'(border), 32'd5);
        check("wr_mic", 32'(mic), 32'd0);
        check("wr_beeper", 32'(beeper), 32'd1);
        data_in = 8'h07;
        step();
        check("wr_hold2_border", 32'(border), 32'd5);
        step();
        check("wr_hold3_border", 32'(border), 32'd5);
        check("wr_hold3_beeper", 32'(beeper), 32'd1);
        idle();
        step();

        // Interrupt acknowledge is not a port access
        address_bus = 16'h0000; data_in = 8'h1A; m1_n = 1'b0; iorq_n = 1'b0;
        rd_n = 1'b0; wr_n = 1'b0;
        #1;
        check("ack_oe", 32'(data_oe), 32'd0);
        step();
        check("ack_no_latch", 32'(border), 32'd5);
        idle();
        step();

        // Acknowledge during the INT window
        wait_wrap();
        step();
        m1_n = 1'b0; iorq_n = 1'b0;
        step();
        idle();
`ifdef INTACK_CLEAR_EN
        check("ack_clear_fc2", 32'(int_n), 32'd1);
        step();
        check("ack_clear_fc3", 32'(int_n), 32'd1);
`else
        check("noack_fc2", 32'(int_n), 32'd0);
        step();
        check("noack_fc3", 32'(int_n), 32'd0);
`endif
        step();
        check("ack_fc4", 32'(int_n), 32'd1);

        // Reset in the middle of the INT window
        wait_wrap();
        step(); step();
        check("mid_int_low", 32'(int_n), 32'd0);
        reset_n = 1'b0;
        #1;
        check("async_rst_int_n", 32'(int_n), 32'd1);
        check("async_rst_border", 32'(border), 32'd0);
        check("async_rst_cnt", 32'(frame_cnt), 32'd0);
        step(); step();
        reset_n = 1'b1;
        repeat (99) step();
        check("post_rst_int_high", 32'(int_n), 32'd1);
        step();
        check("post_rst_int_fall", 32'(int_n), 32'd0);

        // Randomised traffic with occasional async reset pulses
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                iorq_n      = 1'($urandom_range(0, 1));
                rd_n        = 1'($urandom_range(0, 1));
                wr_n        = 1'($urandom_range(0, 1));
                m1_n        = ($urandom_range(0, 3) != 0);
                address_bus = 16'($urandom);
            end
            data_in  = 8'($urandom);
            ear      = 1'($urandom_range(0, 1));
            kb_col_n = 5'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 1'b0;
                #1;
                check("rnd_rst_int_n", 32'(int_n), 32'd1);
                reset_n = 1'b1;
            end
            step();
        end

        idle();
        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/zx_ula_io.md
Name: zx_ula_io

Overview:
- ULA-side control stage next to the Z80 core. Generates the frame-synchronous maskable interrupt that drives the CPU `int_n` input.
- Decodes CPU I/O cycles to port 0xFE (even address):
  - writes latch border colour, MIC and beeper;
  - reads return keyboard columns and EAR.
- Sits between the CPU control/address buses and the video, audio and keyboard logic. Read data goes to the top-level data-bus mux.

Parameters:
- FRAME_TSTATES, 69888, T-states per frame; frame counter period.
- INT_LEN, 32, T-states `int_n` is held low per frame.
- CNT_W, 17, frame counter width; must satisfy 2^CNT_W >= FRAME_TSTATES.

Ports:
- clk  in  1  CPU T-state clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address_bus  in  16  CPU address.
- data_in  in  8  CPU write data (output side of the CPU data bus).
- iorq_n  in  1  CPU IORQ, active low.
- rd_n  in  1  CPU RD, active low.
- wr_n  in  1  CPU WR, active low.
- m1_n  in  1  CPU M1, active low.
- ear  in  1  tape EAR input.
- kb_col_n  in  5  keyboard column lines for rows selected by address_bus[15:8], active low.
- int_n  out  1  maskable interrupt to CPU, active low, registered.
- data_out  out  8  port read data.
- data_oe  out  1  high when data_out must drive the CPU data bus.
- border  out  3  border colour.
- mic  out  1  MIC output.
- beeper  out  1  speaker output.
- frame_tick  out  1  one-cycle pulse at frame start.
- frame_cnt  out  CNT_W  current T-state in frame.

Behaviour:
- Reset (async, reset_n=0):
  - frame_cnt=0, int_n=1, frame_tick=0, border=3'b000, mic=0, beeper=0;
  - internal `wrapped`=0, write-edge flag cleared;
  - outputs change immediately, without waiting for clk.
- Frame counter:
  - increments every clk;
  - the value FRAME_TSTATES-1 is followed by 0 (wrap); never reaches FRAME_TSTATES;
  - `wrapped` sets on the first wrap and stays set until reset.
- Interrupt:
  - on every wrap edge, int_n<=0 and frame_tick<=1 for that one cycle;
  - int_n returns to 1 on the edge where frame_cnt becomes INT_LEN, so it is low exactly INT_LEN cycles;
  - no interrupt before the first wrap: the first int_n fall is at the 69888th rising edge after reset release.
- I/O decode (combinational):
  - io_rd = !iorq_n & !rd_n & m1_n & !address_bus[0];
  - io_wr = !iorq_n & !wr_n & m1_n & !address_bus[0];
  - any cycle with m1_n=0 (interrupt acknowledge) is never a port access.
- Read path:
  - data_oe = io_rd;
  - data_out = {1'b1, ear, 1'b1, kb_col_n[4:0]} at all times;
  - 0 cycles latency.
- Write path:
  - on the first rising clk where io_wr=1 after a cycle with io_wr=0, latch border<=data_in[2:0], mic<=data_in[3], beeper<=data_in[4];
  - an io_wr held for multiple cycles latches once, with data from the first cycle;
  - back-to-back writes need ≥1 cycle of io_wr=0 between them.
- Simultaneous events:
  - an I/O write during the interrupt window is serviced normally;
  - a wrap coinciding with an io_wr updates both independently.
- Reset mid-interrupt: int_n returns high asynchronously, and the next interrupt is one full frame after release.

Optional Feature:
- Macro INTACK_CLEAR_EN.
- Defined:
  - an interrupt acknowledge (m1_n=0 & iorq_n=0 sampled while int_n=0) sets int_n<=1 on the next edge;
  - int_n stays high until the next wrap, even if frame_cnt<INT_LEN.
- Undefined: int_n is always low for the full INT_LEN cycles, and acknowledge cycles have no effect.

Test Plan:
- Reset: FRAME_TSTATES=100, INT_LEN=4, release reset → int_n=1 for edges 1..99; int_n=0 and frame_tick=1 at edge 100; int_n=1 at edge 104. Repeats every 100 edges.
- Read: address_bus=16'hFDFE, iorq_n=0, rd_n=0, m1_n=1, kb_col_n=5'b11110, ear=1 → same cycle data_oe=1, data_out=8'hFE. With address_bus=16'hFDFF → data_oe=0.
- Write: address_bus=16'h00FE, data_in=8'h15, io_wr held 3 cycles, data_in changed to 8'h07 on cycle 2 → border=3'b101, mic=0, beeper=1, unchanged after the 2nd and 3rd cycles.
- Acknowledge is not a port: m1_n=0, iorq_n=0, rd_n=0, address_bus[0]=0 → data_oe=0, no latch.
- Reset mid-interrupt: assert reset_n=0 at frame_cnt=2 of an interrupt window → int_n=1 and border=0 immediately. Next int_n fall 100 edges after release.
- INTACK_CLEAR_EN: acknowledge at frame_cnt=1 → int_n=1 from the next edge, stays 1 until the next wrap. Without the macro, int_n stays low through frame_cnt=3.
